// File: rtl/constraint_candidate_sampler.sv
// constraint_candidate_sampler
//   Generates pseudo-random candidate assignments for var_0..var_4 from a 64-bit
//   Galois LFSR. It feeds each candidate to an external combinational constraint
//   checker and retries until every cons_ok bit is set or MAX_TRIES candidates
//   have been tried. An accepted candidate is presented on a valid/ready stream.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   seed_load, seed_in  reseed the LFSR while idle (a zero seed selects SEED)
//   start               request one satisfying sample (idle only)
//   var_0..var_4        current candidate, combinational slices of the LFSR
//   cons_ok             per-constraint truth bits from the checker
//   sample_valid/ready  output stream handshake, sample_data = accepted candidate
//   busy                request in flight
//   timeout             sticky: the last request ran out of tries
//   tries               candidates evaluated for the current/last request
module constraint_candidate_sampler #(
  parameter logic [63:0] SEED      = 64'h9E37_79B9_7F4A_7C15,
  parameter int unsigned MAX_TRIES = 1024,
  parameter int unsigned NUM_CONS  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                seed_load,
  input  logic [63:0]         seed_in,
  input  logic                start,
  output logic [12:0]         var_0,
  output logic [12:0]         var_1,
  output logic [13:0]         var_2,
  output logic [13:0]         var_3,
  output logic [7:0]          var_4,
  input  logic [NUM_CONS-1:0] cons_ok,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic [61:0]         sample_data,
  output logic                busy,
  output logic                timeout,
  output logic [15:0]         tries
);

  // x^64 + x^63 + x^61 + x^60 + 1, right-shifting Galois form
  localparam logic [63:0] LfsrTaps = 64'hD800_0000_0000_0000;
  localparam logic [15:0] MaxTries = 16'(MAX_TRIES);

  typedef enum logic [1:0] {
    StIdle,
    StGen,
    StCheck,
    StHold
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] lfsr_q, lfsr_d;
  logic        sample_valid_q, sample_valid_d;
  logic [61:0] sample_data_q, sample_data_d;
  logic        timeout_q, timeout_d;
  logic [15:0] tries_q, tries_d;

  logic [63:0] lfsr_step;
  logic [61:0] candidate;
  logic [15:0] tries_inc;

  always_comb begin
    lfsr_step = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_step = lfsr_step ^ LfsrTaps;
    end
  end

  assign candidate = lfsr_q[61:0];
  assign tries_inc = tries_q + 16'd1;

  assign var_0 = lfsr_q[12:0];
  assign var_1 = lfsr_q[25:13];
  assign var_2 = lfsr_q[39:26];
  assign var_3 = lfsr_q[53:40];
  assign var_4 = lfsr_q[61:54];

  always_comb begin
    state_d        = state_q;
    lfsr_d         = lfsr_q;
    sample_valid_d = sample_valid_q;
    sample_data_d  = sample_data_q;
    timeout_d      = timeout_q;
    tries_d        = tries_q;

    unique case (state_q)
      StIdle: begin
        // Reseeding wins over a simultaneous start, which is then dropped.
        if (seed_load) begin
          lfsr_d = (seed_in == 64'd0) ? SEED : seed_in;
        end else if (start) begin
          tries_d   = 16'd0;
          timeout_d = 1'b0;
          state_d   = StGen;
        end
      end
      StGen: begin
        lfsr_d  = lfsr_step;
        state_d = StCheck;
      end
      StCheck: begin
        tries_d = tries_inc;
        // A pass on the final try is still a success.
        if (&cons_ok) begin
          sample_data_d  = candidate;
          sample_valid_d = 1'b1;
          state_d        = StHold;
        end else if (tries_inc == MaxTries) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          state_d = StGen;
        end
      end
      StHold: begin
        if (sample_ready) begin
          sample_valid_d = 1'b0;
          state_d        = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      lfsr_q         <= SEED;
      sample_valid_q <= 1'b0;
      sample_data_q  <= 62'd0;
      timeout_q      <= 1'b0;
      tries_q        <= 16'd0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      sample_valid_q <= sample_valid_d;
      sample_data_q  <= sample_data_d;
      timeout_q      <= timeout_d;
      tries_q        <= tries_d;
    end
  end

  assign sample_valid = sample_valid_q;
  assign sample_data  = sample_data_q;
  assign timeout      = timeout_q;
  assign tries        = tries_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_constraint_candidate_sampler.sv
// Directed bench for constraint_candidate_sampler. cons_ok is driven either as a
// forced constant, as "all ones only for one chosen candidate", or by a small
// stand-in constraint function over var_*. An independent LFSR model predicts
// every candidate.
module tb_constraint_candidate_sampler;

  localparam logic [63:0] SEED = 64'h9E37_79B9_7F4A_7C15;
  localparam int unsigned MT   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [63:0] seed_in;
  logic        start;
  logic [12:0] var_0;
  logic [12:0] var_1;
  logic [13:0] var_2;
  logic [13:0] var_3;
  logic [7:0]  var_4;
  logic [7:0]  cons_ok;
  logic        sample_valid;
  logic        sample_ready;
  logic [61:0] sample_data;
  logic        busy;
  logic        timeout;
  logic [15:0] tries;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cons_mode;
  logic [7:0]  cons_force;
  logic [61:0] target;

  constraint_candidate_sampler #(
    .SEED      (SEED),
    .MAX_TRIES (MT),
    .NUM_CONS  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .seed_load    (seed_load),
    .seed_in      (seed_in),
    .start        (start),
    .var_0        (var_0),
    .var_1        (var_1),
    .var_2        (var_2),
    .var_3        (var_3),
    .var_4        (var_4),
    .cons_ok      (cons_ok),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_data  (sample_data),
    .busy         (busy),
    .timeout      (timeout),
    .tries        (tries)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    logic [63:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 64'hD800_0000_0000_0000;
    return r;
  endfunction

  // Stand-in constraint block: eight loose predicates over the candidate.
  function automatic logic [7:0] cons_fn(input logic [61:0] c);
    logic [12:0] a, b;
    logic [13:0] x, y, sxy;
    logic [7:0]  z, r;
    a    = c[12:0];
    b    = c[25:13];
    x    = c[39:26];
    y    = c[53:40];
    z    = c[61:54];
    sxy  = x + y;
    r[0] = (a != 13'd0);
    r[1] = (b != a);
    r[2] = (sxy != 14'd0);
    r[3] = (z != 8'hFF);
    r[4] = (a[1:0] != 2'd0);
    r[5] = ((b ^ x[12:0]) != 13'd0);
    r[6] = (y > 14'd100);
    r[7] = z[0] | x[0];
    return r;
  endfunction

  always_comb begin
    cons_ok = cons_force;
    if (cons_mode == 1) begin
      cons_ok = cons_fn({var_4, var_3, var_2, var_1, var_0});
    end else if (cons_mode == 2) begin
      cons_ok = ({var_4, var_3, var_2, var_1, var_0} == target) ? 8'hFF : 8'h00;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses start and waits for a sample or for the request to end.
  // lat counts falling edges from the start edge to the observing edge.
  task automatic run_req(output logic got_valid, output int lat);
    got_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (lat < 40) begin
      if (sample_valid) begin
        got_valid = 1'b1;
        break;
      end
      if (!busy) break;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic ack();
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] model;
    logic [63:0] s1;
    logic [63:0] m3;
    logic [61:0] d_a;
    logic        gv;
    logic        exp_ok;
    int          lat;
    int          exp_tries;

    rst          = 1'b1;
    seed_load    = 1'b0;
    seed_in      = 64'd0;
    start        = 1'b0;
    sample_ready = 1'b0;
    cons_mode    = 0;
    cons_force   = 8'h00;
    target       = 62'd0;
    model        = SEED;
    s1           = lfsr_next(SEED);

    // Reset state
    #12;
    chk("rst_valid", sample_valid, 0);
    chk("rst_data", sample_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_tries", tries, 0);
    chk("rst_var0", var_0, model[12:0]);
    chk("rst_var4", var_4, model[61:54]);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // First sample with every constraint forced true
    cons_force = 8'hFF;
    run_req(gv, lat);
    model = s1;
    chk("t1_valid", gv, 1);
    chk("t1_lat", lat, 3);
    chk("t1_data", sample_data, model[61:0]);
    chk("t1_tries", tries, 1);
    chk("t1_timeout", timeout, 0);
    chk("t1_var1", var_1, model[25:13]);
    ack();
    chk("t1_valid_clr", sample_valid, 0);
    chk("t1_idle", busy, 0);
    chk("t1_tries_hold", tries, 1);

    // Zero seed selects SEED; seed_load beats a simultaneous start
    seed_load = 1'b1;
    seed_in   = 64'd0;
    start     = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    start     = 1'b0;
    chk("t2_start_ignored", busy, 0);
    chk("t2_reseed_var0", var_0, SEED[12:0]);
    run_req(gv, lat);
    chk("t2_zero_seed_data", sample_data, s1[61:0]);
    d_a = sample_data;
    ack();
    seed_load = 1'b1;
    seed_in   = SEED;
    @(negedge clk);
    seed_load = 1'b0;
    run_req(gv, lat);
    chk("t2_same_sample", sample_data, d_a);
    ack();
    model = s1;

    // Timeout after MT failing candidates
    cons_force = 8'hFE;
    run_req(gv, lat);
    for (int k = 0; k < 4; k++) model = lfsr_next(model);
    chk("t3_no_valid", gv, 0);
    chk("t3_lat", lat, 9);
    chk("t3_timeout", timeout, 1);
    chk("t3_tries", tries, 4);
    chk("t3_busy", busy, 0);
    chk("t3_var2", var_2, model[39:26]);

    // Only the third candidate passes; hold off ready
    m3 = lfsr_next(lfsr_next(lfsr_next(model)));
    target    = m3[61:0];
    cons_mode = 2;
    run_req(gv, lat);
    chk("t4_valid", gv, 1);
    chk("t4_lat", lat, 7);
    chk("t4_tries", tries, 3);
    chk("t4_timeout_clr", timeout, 0);
    chk("t4_data", sample_data, m3[61:0]);
    for (int k = 0; k < 5; k++) begin
      start = (k == 0);
      @(negedge clk);
      start = 1'b0;
      chk("t4_hold_valid", sample_valid, 1);
      chk("t4_hold_data", sample_data, m3[61:0]);
    end
    ack();
    chk("t4_valid_clr", sample_valid, 0);
    chk("t4_idle", busy, 0);
    model     = m3;
    cons_mode = 0;

    // Reset during CHECK
    cons_force = 8'hFE;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t5a_busy", busy, 0);
    chk("t5a_valid", sample_valid, 0);
    chk("t5a_tries", tries, 0);
    chk("t5a_var0", var_0, SEED[12:0]);
    @(negedge clk);
    rst = 1'b0;
    cons_force = 8'hFF;
    run_req(gv, lat);
    chk("t5a_fresh", sample_data, s1[61:0]);

    // Reset during HOLD
    rst = 1'b1;
    #1;
    chk("t5b_valid", sample_valid, 0);
    chk("t5b_data", sample_data, 0);
    chk("t5b_busy", busy, 0);
    chk("t5b_var3", var_3, SEED[53:40]);
    @(negedge clk);
    rst = 1'b0;
    run_req(gv, lat);
    chk("t5b_fresh", sample_data, s1[61:0]);
    chk("t5b_tries", tries, 1);
    ack();
    model = s1;

    // 50 requests against the stand-in constraint block
    cons_mode = 1;
    for (int r = 0; r < 50; r++) begin
      exp_ok    = 1'b0;
      exp_tries = int'(MT);
      for (int k = 1; k <= int'(MT); k++) begin
        model = lfsr_next(model);
        if (cons_fn(model[61:0]) == 8'hFF) begin
          exp_ok    = 1'b1;
          exp_tries = k;
          break;
        end
      end
      run_req(gv, lat);
      chk("t6_valid", gv, exp_ok);
      chk("t6_tries", tries, exp_tries);
      chk("t6_timeout", timeout, !exp_ok);
      if (exp_ok) begin
        chk("t6_data", sample_data, model[61:0]);
        chk("t6_reapply", cons_fn(sample_data), 8'hFF);
        ack();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/constraint_candidate_sampler.md
Name: constraint_candidate_sampler

Overview:
- Upstream stimulus stage for a generated constraint module: produces pseudo-random candidate assignments for var_0..var_4 (13/13/14/14/8 bits) from a 64-bit LFSR.
- Drives each candidate into the combinational constraint block and samples its reduced per-constraint truth bits (cons_ok).
- Retries until every constraint holds or a try budget is exhausted.
- Accepted solutions leave on a valid/ready stream toward the testbench or solution log.

Parameters:
SEED, 64'h9E37_79B9_7F4A_7C15, default LFSR state after reset, also used if loaded seed is zero
MAX_TRIES, 1024, candidates evaluated per request before timeout (1..65535)
NUM_CONS, 8, number of constraint truth bits checked

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
seed_load  in  1  load seed_in into LFSR (IDLE only, otherwise ignored)
seed_in  in  64  seed value
start  in  1  request one satisfying sample (accepted in IDLE only)
var_0  out  13  candidate, LFSR[12:0]
var_1  out  13  candidate, LFSR[25:13]
var_2  out  14  candidate, LFSR[39:26]
var_3  out  14  candidate, LFSR[53:40]
var_4  out  8  candidate, LFSR[61:54]
cons_ok  in  NUM_CONS  bit i = (constraint_i != 0) from checker, combinational from var_*
sample_valid  out  1  accepted sample presented
sample_ready  in  1  consumer accepts sample
sample_data  out  62  {var_4,var_3,var_2,var_1,var_0} of accepted candidate
busy  out  1  high in GEN/CHECK/HOLD
timeout  out  1  sticky: last request exhausted MAX_TRIES
tries  out  16  candidates evaluated for current/last request

Behaviour:
- Reset (async): state IDLE; LFSR=SEED; var_* = SEED slices; sample_valid=0, sample_data=0, busy=0, timeout=0, tries=0. Reset mid-request aborts without output.
- LFSR: 64-bit Galois, polynomial x^64+x^63+x^61+x^60+1. Step: lsb=s[0]; s>>=1; if lsb, s ^= 64'hD800_0000_0000_0000. Steps only on entry to CHECK. var_* are combinational slices of the registered state.
- seed_load in IDLE: LFSR <= (seed_in==0) ? SEED : seed_in. It has priority over start in the same cycle; start is then ignored.
- FSM:
  - IDLE: on start, tries<=0, timeout<=0, go to GEN.
  - GEN: step LFSR, go to CHECK.
  - CHECK: cons_ok is sampled against the stepped state (checker settles within one cycle). tries<=tries+1.
    - If &cons_ok: sample_data<=current var_* concatenation, sample_valid<=1, go to HOLD.
    - Else if tries+1==MAX_TRIES: timeout<=1, go to IDLE.
    - Else: go to GEN.
  - HOLD: sample_valid and sample_data stay stable until sample_ready. On sample_valid&&sample_ready, sample_valid<=0 next cycle and go to IDLE. var_* stay frozen.
- Each candidate costs 2 cycles. Minimum start-to-valid latency is 3 cycles (start edge, GEN, CHECK, valid registered).
- sample_ready when not valid: ignored. start outside IDLE: ignored; no queueing.
- tries saturates only through the MAX_TRIES check. It holds its value in IDLE for readback.
- busy = (state != IDLE), registered with the state.
- A timeout request sets no sample_valid. A timeout that coincides with the final try passing counts as success: the all-ones check wins over the timeout.

Test Plan:
- Reset, then start with the bench forcing cons_ok=8'hFF -> sample_valid rises 3 cycles after start; sample_data equals the concatenation of var_* after one LFSR step from SEED; tries=1; timeout=0.
- seed_load with seed_in=0 followed by start; compare against a run with seed_load seed_in=SEED -> identical sample_data in both.
- cons_ok=8'hFE constant, MAX_TRIES=4 -> exactly 4 CHECK cycles; timeout=1, tries=4, busy drops, no sample_valid.
- cons_ok=8'hFF only on the 3rd candidate -> sample_valid with tries=3; sample_ready held low 5 cycles -> sample_data stable; ready pulse -> valid clears next cycle, FSM returns to IDLE.
- Assert rst during CHECK and during HOLD -> all outputs return to reset values immediately; next start reproduces the same sample as a fresh run.
- Connect the real generated constraint module; run 50 requests -> every sample_data, re-applied to that module, gives all constraint outputs nonzero.
